// File: rtl/rr_mux4_to_1.sv
// -----------------------------------------------------------------------------
// rr_mux4_to_1
//
// Merges four valid/ready input channels into one registered output stream.
// A round-robin arbiter selects one requesting channel per transfer. The
// output register holds the data word together with the 2-bit index of the
// channel it came from. That index uses the same encoding that a downstream
// demux1_to_4 expects on its sel input.
//
// Parameters
//   DW         data width of each input channel and of out_data
//
// Ports
//   clk        single clock; all state changes on the rising edge
//   rst        synchronous active-high reset
//   in_valid   per-channel request, bit i = channel i
//   in_data    channel i data at [i*DW +: DW]
//   in_ready   one-hot-or-zero; bit i means channel i transfers this cycle
//   out_valid  output register holds a word
//   out_data   registered data word
//   out_sel    index of the channel that out_data came from
//   out_ready  downstream accepts the word when out_valid & out_ready
// -----------------------------------------------------------------------------
module rr_mux4_to_1 #(
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      in_valid,
    input  logic [4*DW-1:0] in_data,
    output logic [3:0]      in_ready,
    output logic            out_valid,
    output logic [DW-1:0]   out_data,
    output logic [1:0]      out_sel,
    input  logic            out_ready
);

    // Index of the most recently granted channel. The search for the next
    // grant starts one position after it.
    logic [1:0]    last_grant;

    // Split the flat data bus into per-channel words so that the data mux
    // can index by grant directly.
    logic [DW-1:0] ch_word [4];

    for (genvar g = 0; g < 4; g++) begin : g_split
        assign ch_word[g] = in_data[g*DW +: DW];
    end

    // The output register can accept a new word when it is empty, or when
    // its current word is being drained in this same cycle. A simultaneous
    // drain and load therefore adds no bubble.
    logic load;
    assign load = ~out_valid | out_ready;

    logic any_valid;
    assign any_valid = |in_valid;

    // Round-robin search. Rotate the request vector so that position 0 is
    // the channel just after last_grant. A fixed priority encoder then picks
    // the first set bit, and adding the offset back gives the grant index.
    // With last_grant = 3, the search starts at 0, so the lowest request wins.
    logic [1:0] base;
    logic [7:0] req_twice;
    logic [3:0] req_rot;
    logic [1:0] offset;
    logic [1:0] grant;

    assign base      = last_grant + 2'd1;
    assign req_twice = {in_valid, in_valid};
    assign req_rot   = req_twice[base +: 4];

    always_comb begin
        // NOTE: every output of a combinational block gets a default value
        // first. Then no path leaves it unassigned, and no latch is inferred.
        offset = 2'd0;
        if (req_rot[0])      offset = 2'd0;
        else if (req_rot[1]) offset = 2'd1;
        else if (req_rot[2]) offset = 2'd2;
        else if (req_rot[3]) offset = 2'd3;
    end

    assign grant = base + offset;

    // The handshake goes to the granted channel only. It is held off when
    // nothing is requesting, when the output is stalled, and during reset,
    // so no channel can see a spurious transfer.
    always_comb begin
        in_ready = 4'b0000;
        if (!rst && load && any_valid) begin
            in_ready = 4'b0001 << grant;
        end
    end

    // Output register and arbiter state.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments. Every
        // register then samples values from before the edge, whatever order
        // the statements are written in.
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_sel    <= 2'd0;
            last_grant <= 2'd3;
        end else if (load) begin
            if (any_valid) begin
                out_valid  <= 1'b1;
                out_data   <= ch_word[grant];
                out_sel    <= grant;
                last_grant <= grant;
            end else begin
                // Drained with nothing to replace it. The data, the index and
                // the rotation point keep their last values.
                out_valid  <= 1'b0;
            end
        end
        // When stalled (out_valid & ~out_ready), everything holds.
    end

endmodule

// File: tb/tb_rr_mux4_to_1.sv
// -----------------------------------------------------------------------------
// Testbench for rr_mux4_to_1.
// A cycle-level reference model predicts in_ready and the output register.
// Each granted word is pushed to a scoreboard queue, and it is popped and
// compared when the DUT presents it on an accepted output transfer.
// -----------------------------------------------------------------------------
module tb_rr_mux4_to_1;

    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0]      in_valid;
    logic [4*DW-1:0] in_data;
    logic [3:0]      in_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [1:0]      out_sel;
    logic            out_ready;

    logic [DW-1:0]   ch_data [4];

    assign in_data = {ch_data[3], ch_data[2], ch_data[1], ch_data[0]};

    always #5 clk = ~clk;

    rr_mux4_to_1 #(.DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic [1:0]    m_sel;
    logic [1:0]    m_last;

    // Scoreboard entries are {sel, data}. grant_log records the model grants.
    logic [DW+1:0] sb_q [$];
    int            grant_log [$];
    int            pop_count = 0;

    // One clock cycle. Inputs are already driven. At the negedge, compare the
    // DUT against the model, then advance the model and wait until just after
    // the posedge.
    task automatic step();
        logic       m_load;
        logic [3:0] exp_ready;
        int         g;
        logic [DW+1:0] exp_word;
        @(negedge clk);
        m_load    = !m_valid || out_ready;
        g         = -1;
        for (int k = 1; k <= 4; k++) begin
            int idx;
            idx = (int'(m_last) + k) % 4;
            if (g < 0 && in_valid[idx]) g = idx;
        end
        exp_ready = (!rst && m_load && g >= 0) ? (4'b0001 << g) : 4'b0000;
        checks++;
        if (in_ready !== exp_ready) begin
            errors++;
            $display("FAIL in_ready t=%0t: got %b expected %b", $time, in_ready, exp_ready);
        end
        checks++;
        if (out_valid !== m_valid) begin
            errors++;
            $display("FAIL out_valid t=%0t: got %b expected %b", $time, out_valid, m_valid);
        end
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_empty t=%0t: got word %h/%0d expected none", $time, out_data, out_sel);
            end else begin
                exp_word = sb_q.pop_front();
                pop_count++;
                if ({out_sel, out_data} !== exp_word) begin
                    errors++;
                    $display("FAIL sb_word t=%0t: got sel=%0d data=%h expected sel=%0d data=%h",
                             $time, out_sel, out_data, exp_word[DW+1:DW], exp_word[DW-1:0]);
                end
            end
        end
        // Advance the model.
        if (rst) begin
            m_valid = 1'b0; m_data = '0; m_sel = 2'd0; m_last = 2'd3;
            sb_q.delete();
        end else if (m_load) begin
            if (g >= 0) begin
                m_valid = 1'b1;
                m_data  = ch_data[g];
                m_sel   = 2'(g);
                m_last  = 2'(g);
                sb_q.push_back({2'(g), ch_data[g]});
                grant_log.push_back(g);
            end else begin
                m_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        rst       = 1'b1;
        #2;
        checks++;
        if (in_ready !== 4'b0000) begin
            errors++; $display("FAIL reset_in_ready: got %b expected 0000", in_ready);
        end
        step(); step();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_sel !== 2'd0) begin
            errors++; $display("FAIL reset_outputs: got v=%b d=%h s=%0d expected 0/00/0",
                               out_valid, out_data, out_sel);
        end
        rst = 1'b0;
        #2;
        checks++;
        if (in_ready !== 4'b0001) begin
            errors++; $display("FAIL reset_first_grant: got %b expected 0001", in_ready);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 8'hA0) begin
            errors++; $display("FAIL reset_first_word: got v=%b s=%0d d=%h expected 1/0/A0",
                               out_valid, out_sel, out_data);
        end
    endtask

    task automatic test_round_robin();
        int exp_seq [5] = '{0, 1, 2, 3, 0};
        in_valid = 4'b1111; out_ready = 1'b1;
        do_reset();
        grant_log.delete();
        for (int b = 0; b < 5; b++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || out_sel !== 2'(exp_seq[b]) ||
                out_data !== 8'hA0 + 8'(exp_seq[b])) begin
                errors++;
                $display("FAIL rr_beat%0d: got v=%b s=%0d d=%h expected 1/%0d/%h", b,
                         out_valid, out_sel, out_data, exp_seq[b], 8'hA0 + 8'(exp_seq[b]));
            end
        end
        checks++;
        if (grant_log.size() != 5) begin
            errors++; $display("FAIL rr_count: got %0d grants expected 5", grant_log.size());
        end
    endtask

    task automatic test_stall();
        int pops_before;
        in_valid = 4'b0000; out_ready = 1'b1;
        step();
        ch_data[2] = 8'h5C;
        in_valid = 4'b0100; out_ready = 1'b0;
        step();
        for (int c = 0; c < 3; c++) begin
            #2;
            checks++;
            if (in_ready !== 4'b0000) begin
                errors++; $display("FAIL stall_in_ready%0d: got %b expected 0000", c, in_ready);
            end
            checks++;
            if (out_valid !== 1'b1 || out_sel !== 2'd2 || out_data !== 8'h5C) begin
                errors++; $display("FAIL stall_hold%0d: got v=%b s=%0d d=%h expected 1/2/5C",
                                   c, out_valid, out_sel, out_data);
            end
            step();
        end
        pops_before = pop_count;
        in_valid = 4'b0000; out_ready = 1'b1;
        step(); step();
        checks++;
        if (pop_count - pops_before != 1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL stall_release: got %0d transfers v=%b expected 1 transfer v=0",
                               pop_count - pops_before, out_valid);
        end
        ch_data[2] = 8'hA2;
    endtask

    task automatic test_skip_channels();
        int exp_seq [3] = '{1, 3, 1};
        do_reset();
        out_ready = 1'b1;
        grant_log.delete();
        in_valid = 4'b0010;
        step();
        in_valid = 4'b1010;
        step(); step();
        checks++;
        if (grant_log.size() != 3) begin
            errors++; $display("FAIL skip_count: got %0d grants expected 3", grant_log.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (grant_log[i] != exp_seq[i]) begin
                    errors++; $display("FAIL skip_grant%0d: got %0d expected %0d", i, grant_log[i], exp_seq[i]);
                end
            end
        end
        checks++;
        if (out_sel !== 2'd1 || out_data !== 8'hA1) begin
            errors++; $display("FAIL skip_word: got s=%0d d=%h expected 1/A1", out_sel, out_data);
        end
    endtask

    task automatic test_idle_hold();
        in_valid = 4'b0000; out_ready = 1'b1;
        for (int c = 0; c < 4; c++) step();
        checks++;
        if (out_valid !== 1'b0 || out_sel !== 2'd1 || out_data !== 8'hA1) begin
            errors++; $display("FAIL idle_hold: got v=%b s=%0d d=%h expected 0/1/A1",
                               out_valid, out_sel, out_data);
        end
        in_valid = 4'b1111;
        #2;
        checks++;
        if (in_ready !== 4'b0100) begin
            errors++; $display("FAIL idle_resume: got %b expected 0100", in_ready);
        end
        step(); step();
        checks++;
        if (out_sel !== 2'd3 || out_data !== 8'hA3) begin
            errors++; $display("FAIL idle_rotation: got s=%0d d=%h expected 3/A3", out_sel, out_data);
        end
    endtask

    task automatic test_reset_midstream();
        in_valid = 4'b0001; out_ready = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b1) begin
            errors++; $display("FAIL mid_setup: got v=%b expected 1", out_valid);
        end
        in_valid = 4'b1111;
        rst = 1'b1;
        #2;
        checks++;
        if (in_ready !== 4'b0000) begin
            errors++; $display("FAIL mid_in_ready: got %b expected 0000", in_ready);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL mid_discard: got v=%b expected 0", out_valid);
        end
        rst = 1'b0; out_ready = 1'b1;
        in_valid = 4'b1110;
        #2;
        checks++;
        if (in_ready !== 4'b0010) begin
            errors++; $display("FAIL mid_restart: got %b expected 0010", in_ready);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_sel !== 2'd1 || out_data !== 8'hA1) begin
            errors++; $display("FAIL mid_first_word: got v=%b s=%0d d=%h expected 1/1/A1",
                               out_valid, out_sel, out_data);
        end
        in_valid = 4'b0000;
        step(); step();
    endtask

    initial begin
        for (int i = 0; i < 4; i++) ch_data[i] = 8'hA0 + 8'(i);
        rst = 1'b1; in_valid = 4'b0000; out_ready = 1'b0;
        m_valid = 1'b0; m_data = '0; m_sel = 2'd0; m_last = 2'd3;
        #1;
        test_reset();
        test_round_robin();
        test_stall();
        test_skip_channels();
        test_idle_hold();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
